sync_fifo_param: RTL and testbench

Parametrised successor to the fixed 16-bit sync_fifo. It is a single-clock FIFO with configurable data width and arbitrary depth, including non-power-of-2 depths. It adds a selectable first-word-fall-through (FWFT) read mode, occupancy count, almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It serves as the common buffering primitive for datapath blocks that need more than a plain full/empty FIFO.

---
 rtl/sync_fifo_param.sv | 121 ++++++++++++
 tb/tb_sync_fifo_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, selectable FWFT read mode,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_acc, wr_acc;

    // Flags come only from registered count, never from the request inputs.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rd_acc      = rd_en && !empty;
        wr_acc      = wr_en && (!full || rd_acc);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  | (wr_en && !wr_acc);
        underflow_d = underflow_q | (rd_en && !rd_acc);

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not cleared; reset only discards it via the pointers.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            always_comb begin
                dout = empty ? '0 : mem_q[rd_ptr_q];
            end
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = rd_acc ? mem_q[rd_ptr_q] : dout_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: standard and FWFT instances share stimulus and one queue-based model.
module tb_sync_fifo_param;

    localparam int DW    = 16;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en;
    logic [DW-1:0] din;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] s_count, f_count;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words plus sticky error bits.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb_q[$];
    bit            m_ovf = 0, m_unf = 0, model_ready = 0;
    bit            r_ok, w_ok;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            sb_q.delete();
            m_ovf       = 0;
            m_unf       = 0;
            model_ready = 1;
        end else if (model_ready) begin
            r_ok = rd_en && (mq.size() > 0);
            w_ok = wr_en && (mq.size() < DEPTH || r_ok);
            if (rd_en && !r_ok) m_unf = 1;
            if (wr_en && !w_ok) m_ovf = 1;
            if (r_ok) sb_q.push_back(mq.pop_front());
            if (w_ok) mq.push_back(din);
        end
    end

    task automatic check_status(input string p, input logic [CW-1:0] c, input logic fu,
                                input logic em, input logic af, input logic ae,
                                input logic ov, input logic un);
        int n;
        n = mq.size();
        check({p, "_count"}, c, n);
        check({p, "_full"}, fu, n == DEPTH);
        check({p, "_empty"}, em, n == 0);
        check({p, "_almost_full"}, af, n >= AF);
        check({p, "_almost_empty"}, ae, n <= AE);
        check({p, "_overflow"}, ov, m_ovf);
        check({p, "_underflow"}, un, m_unf);
    endtask

    // Monitor: a standard-mode word is presented after an edge that saw rd_en with the DUT non-empty.
    logic [DW-1:0] hold = '0;
    logic [DW-1:0] exp_word;
    bit            prev_empty = 1, mon_rd, mon_rst;

    always @(posedge clk) begin
        mon_rd  = rd_en;
        mon_rst = rst;
        #1;
        if (model_ready) begin
            if (mon_rst) begin
                hold = '0;
                check("std_dout", s_dout, hold);
            end else if (mon_rd && !prev_empty) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_pop: DUT presented %h with no expected word", s_dout);
                end else begin
                    exp_word = sb_q.pop_front();
                    check("std_pop", s_dout, exp_word);
                    hold = exp_word;
                end
            end else begin
                check("std_hold", s_dout, hold);
            end
            check("fwft_dout", f_dout, (mq.size() > 0) ? mq[0] : '0);
            check_status("std", s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_unf);
            check_status("fwft", f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_unf);
            prev_empty = s_empty;
        end
    end

    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
        rst   = 1'b0;
        wr_en = w;
        din   = d;
        rd_en = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
    endtask

    int wp, rp;

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_empty", s_empty, 1'b1);
        check("reset_dout", s_dout, 16'h0000);

        // Fill to full, then one rejected write.
        for (int i = 1; i <= 5; i++) drive(1'b1, DW'(i), 1'b0);
        check("plan_full", s_full, 1'b1);
        check("plan_af", s_af, 1'b1);
        drive(1'b1, 16'h0006, 1'b0);
        check("plan_ovf", s_ovf, 1'b1);
        check("plan_ovf_count", s_count, 3'd5);
        drive(1'b0, '0, 1'b0);

        // Drain with pointer wrap.
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
        for (int i = 6; i <= 8; i++) drive(1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1);
        check("plan_wrap_last", s_dout, 16'h0008);
        drive(1'b0, '0, 1'b0);
        check("plan_wrap_empty", s_empty, 1'b1);
        check("plan_wrap_unf", s_unf, 1'b0);

        // Simultaneous read/write while full.
        for (int i = 11; i <= 15; i++) drive(1'b1, DW'(i), 1'b0);
        drive(1'b1, 16'hAAAA, 1'b1);
        check("plan_rw_full_count", s_count, 3'd5);
        check("plan_rw_full_full", s_full, 1'b1);
        check("plan_rw_full_ovf", s_ovf, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1);
        check("plan_rw_full_aaaa", s_dout, 16'hAAAA);

        // Empty corner: write and read together on an empty FIFO.
        drive(1'b1, 16'h1234, 1'b1);
        check("plan_corner_unf", s_unf, 1'b1);
        check("plan_corner_count", s_count, 3'd1);
        check("plan_corner_dout", s_dout, 16'hAAAA);
        drive(1'b0, '0, 1'b1);
        check("plan_corner_read", s_dout, 16'h1234);

        // Fall-through visibility.
        do_reset();
        rst = 1'b0; wr_en = 1'b1; din = 16'hBEEF; rd_en = 1'b0;
        check("plan_fwft_pre", f_dout, 16'h0000);
        @(negedge clk);
        wr_en = 1'b0;
        check("plan_fwft_head", f_dout, 16'hBEEF);
        check("plan_fwft_nonempty", f_empty, 1'b0);
        drive(1'b0, '0, 1'b1);
        check("plan_fwft_pop_empty", f_empty, 1'b1);
        check("plan_fwft_pop_dout", f_dout, 16'h0000);

        // Reset mid-operation with a write pending.
        for (int i = 1; i <= 6; i++) drive(1'b1, DW'(16'h0100 + i), 1'b0);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        check("plan_mid_count", s_count, 3'd3);
        check("plan_mid_ovf", s_ovf, 1'b1);
        rst = 1'b1; wr_en = 1'b1; din = 16'h7777; rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;
        check("plan_rst_count", s_count, 3'd0);
        check("plan_rst_ovf", s_ovf, 1'b0);
        check("plan_rst_dout", s_dout, 16'h0000);
        drive(1'b1, 16'h5A5A, 1'b0);
        drive(1'b0, '0, 1'b1);
        check("plan_rst_5a5a", s_dout, 16'h5A5A);

        // Randomised traffic with shifting write/read bias and rare resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                wp = $urandom_range(20, 90);
                rp = $urandom_range(20, 90);
            end
            rst   = ($urandom_range(0, 199) == 0);
            wr_en = ($urandom_range(0, 99) < wp);
            rd_en = ($urandom_range(0, 99) < rp);
            din   = DW'($urandom);
            @(negedge clk);
        end
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
